vec_pe: RTL and testbench

- Parametrised successor to the single-lane serial PE.
- Computes a LANES-wide signed dot product per valid beat (neuron × weight, summed) and accumulates beats into a running partial sum.
- Emits the final sum when a beat is marked last.
- Sits between the neuron/weight buffers and the output/activation stage of the accelerator datapath.
- Fixed 3-stage pipeline, no backpressure.

---
 rtl/vec_pe_pkg.sv | 27 ++
 rtl/vec_pe_addtree.sv | 34 +++
 rtl/vec_pe.sv | 139 +++++++++++++
 tb/tb_vec_pe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_pe_pkg.sv
// vec_pe_pkg: control-bit indices and width/saturation helpers shared by the vec_pe datapath.
package vec_pe_pkg;

    localparam int unsigned CTL_ACC  = 0;
    localparam int unsigned CTL_LAST = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned lanes);
        return 2 * data_w + clog2(lanes);
    endfunction

    // Callers truncate these to the accumulator width.
    function automatic logic [127:0] sat_max(input int unsigned w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    function automatic logic [127:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/vec_pe_addtree.sv
// vec_pe_addtree: registered sum of LANES signed products, sign-extended to SUM_W (stage 2).
module vec_pe_addtree
    import vec_pe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int PROD_W = 32,
    parameter int SUM_W  = PROD_W + clog2(LANES)
) (
    input  logic                      clk,
    input  logic                      en_i,
    input  logic [LANES*PROD_W-1:0]   prod_i,
    output logic [SUM_W-1:0]          sum_o
);

    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_q;
    logic signed [PROD_W-1:0] p;

    always_comb begin
        sum_d = '0;
        p     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            p     = prod_i[i*PROD_W +: PROD_W];
            sum_d = sum_d + SUM_W'(p);
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) sum_q <= sum_d;
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/vec_pe.sv
// vec_pe: LANES-wide signed dot-product PE with beat accumulation, 3-stage pipeline.
// Define VEC_PE_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module vec_pe
    import vec_pe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*DATA_W-1:0]   neuron,
    input  logic [LANES*DATA_W-1:0]   weight,
    input  logic [1:0]                ctl,
    input  logic                      vld_i,
    output logic [ACC_W-1:0]          result,
    output logic                      vld_o,
    output logic                      ovf_o,
    output logic [CNT_W-1:0]          beats_o
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = sum_w(DATA_W, LANES);
    localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

`ifdef VEC_PE_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
`endif

    // Stage 1: per-lane products
    logic [LANES*PROD_W-1:0]  prod_d, prod_q;
    logic signed [DATA_W-1:0] na, wb;
    logic signed [PROD_W-1:0] pr;
    logic [1:0]               ctl1_q;
    logic                     vld1_q;

    always_comb begin
        prod_d = '0;
        na     = '0;
        wb     = '0;
        pr     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            na = neuron[i*DATA_W +: DATA_W];
            wb = weight[i*DATA_W +: DATA_W];
            pr = na * wb;
            prod_d[i*PROD_W +: PROD_W] = pr;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_i) begin
            prod_q <= prod_d;
            ctl1_q <= ctl;
        end
    end

    // Stage 2: adder tree
    logic [SUM_W-1:0] sum2;
    logic [1:0]       ctl2_q;
    logic             vld2_q;

    vec_pe_addtree #(
        .LANES  (LANES),
        .PROD_W (PROD_W),
        .SUM_W  (SUM_W)
    ) u_addtree (
        .clk    (clk),
        .en_i   (vld1_q),
        .prod_i (prod_q),
        .sum_o  (sum2)
    );

    always_ff @(posedge clk) begin
        if (vld1_q) ctl2_q <= ctl1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
        end else begin
            vld1_q <= vld_i;
            vld2_q <= vld1_q;
        end
    end

    // Stage 3: accumulate, count beats, track overflow
    logic signed [ACC_W-1:0] acc_q, acc_d, wrap;
    logic signed [EXT_W-1:0] exact;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    flag_q, flag_d, ovf_now;

    always_comb begin
        exact = EXT_W'($signed(sum2));
        if (ctl2_q[CTL_ACC]) exact = exact + EXT_W'(acc_q);
        wrap    = exact[ACC_W-1:0];
        ovf_now = (EXT_W'(wrap) != exact);
`ifdef VEC_PE_SATURATE_EN
        acc_d = ovf_now ? (exact[EXT_W-1] ? ACC_MIN : ACC_MAX) : wrap;
`else
        acc_d = wrap;
`endif
        if (!ctl2_q[CTL_ACC]) begin
            cnt_d  = CNT_W'(1);
            flag_d = ovf_now;
        end else begin
            cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            flag_d = flag_q | ovf_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            result  <= '0;
            vld_o   <= 1'b0;
            ovf_o   <= 1'b0;
            beats_o <= '0;
        end else begin
            vld_o <= 1'b0;
            if (vld2_q) begin
                acc_q  <= acc_d;
                cnt_q  <= cnt_d;
                flag_q <= flag_d;
                if (ctl2_q[CTL_LAST]) begin
                    result  <= acc_d;
                    ovf_o   <= flag_d;
                    beats_o <= cnt_d;
                    vld_o   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_pe.sv
// tb_vec_pe: directed vectors for vec_pe; expected results queued at issue, checked by a monitor on vld_o.
module tb_vec_pe;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 16;
`ifdef VEC_PE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LANES*DATA_W-1:0] neuron, weight;
    logic [1:0]              ctl;
    logic                    vld_i;
    logic [ACC_W-1:0]        result;
    logic                    vld_o, ovf_o;
    logic [CNT_W-1:0]        beats_o;

    vec_pe #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .neuron  (neuron),
        .weight  (weight),
        .ctl     (ctl),
        .vld_i   (vld_i),
        .result  (result),
        .vld_o   (vld_o),
        .ovf_o   (ovf_o),
        .beats_o (beats_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ACC_W-1:0] r;
        logic             o;
        logic [CNT_W-1:0] b;
        int unsigned      at;
    } exp_t;

    exp_t        sb[$];
    int unsigned nchk  = 0;
    int unsigned nfail = 0;
    int unsigned drv_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic beat(input logic [63:0] n, input logic [63:0] w, input logic [1:0] c);
        @(negedge clk);
        neuron  = n;
        weight  = w;
        ctl     = c;
        vld_i   = 1'b1;
        drv_cyc = cyc;
    endtask

    task automatic bubble();
        @(negedge clk);
        vld_i  = 1'b0;
        ctl    = 2'($urandom);
        neuron = {$urandom, $urandom};
        weight = {$urandom, $urandom};
    endtask

    // Expected response for the beat just issued: vld_o three edges after issue.
    task automatic expect_out(input logic [ACC_W-1:0] r, input logic o, input logic [CNT_W-1:0] b);
        exp_t e;
        e.r  = r;
        e.o  = o;
        e.b  = b;
        e.at = drv_cyc + 3;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (vld_o) begin
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_vld_o: got result 0x%0h with no expected entry (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",  64'(result),  64'(e.r));
                chk("ovf_o",   64'(ovf_o),   64'(e.o));
                chk("beats_o", 64'(beats_o), 64'(e.b));
                chk("latency", 64'(cyc),     64'(e.at));
            end
        end
    end

    localparam logic [63:0] N5   = 64'h0005_0005_0005_0005;
    localparam logic [63:0] W3   = 64'h0003_0003_0003_0003;
    localparam logic [63:0] WM1  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NEG  = 64'h8000_8000_8000_8000;
    localparam logic [63:0] POS  = 64'h7FFF_7FFF_7FFF_7FFF;
    localparam logic [63:0] ONES = 64'h0001_0001_0001_0001;

    initial begin
        logic [63:0] n1234;
        n1234  = p4(1, 2, 3, 4);
        rst    = 1'b1;
        vld_i  = 1'b0;
        ctl    = 2'b00;
        neuron = '0;
        weight = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", 64'(result),  64'd0);
        chk("reset_vld_o",  64'(vld_o),   64'd0);
        chk("reset_ovf_o",  64'(ovf_o),   64'd0);
        chk("reset_beats",  64'(beats_o), 64'd0);
        rst = 1'b0;

        // single beat
        beat(N5, W3, 2'b10);            expect_out(32'd60, 1'b0, 16'd1);
        bubble();

        // three-beat accumulate
        beat(n1234, ONES, 2'b00);
        beat(n1234, ONES, 2'b01);
        beat(n1234, ONES, 2'b11);       expect_out(32'd30, 1'b0, 16'd3);

        // same with bubbles carrying junk
        bubble();
        beat(n1234, ONES, 2'b00);
        bubble();
        bubble();
        beat(n1234, ONES, 2'b01);
        bubble();
        beat(n1234, ONES, 2'b11);       expect_out(32'd30, 1'b0, 16'd3);
        bubble();
        bubble();

        // positive overflow: 4 * 2^30 = 2^32
        beat(NEG, NEG, 2'b10);          expect_out(SAT ? 32'h7FFF_FFFF : 32'h0, 1'b1, 16'd1);

        // back-to-back single-beat products
        beat(N5, W3, 2'b10);            expect_out(32'd60, 1'b0, 16'd1);
        beat(N5, WM1, 2'b10);           expect_out(32'hFFFF_FFEC, 1'b0, 16'd1);

        // sticky overflow across beats, then a fresh load clears it
        beat(NEG, NEG, 2'b00);
        beat(N5, W3, 2'b11);            expect_out(SAT ? 32'h7FFF_FFFF : 32'd60, 1'b1, 16'd2);
        beat(N5, W3, 2'b10);            expect_out(32'd60, 1'b0, 16'd1);

        // negative overflow: 4 * -(2^30 - 2^15) wraps to 2^17
        beat(NEG, POS, 2'b10);          expect_out(SAT ? 32'h8000_0000 : 32'h0002_0000, 1'b1, 16'd1);
        bubble();
        bubble();
        bubble();
        bubble();

        // reset while the last beat is in flight
        beat(n1234, ONES, 2'b00);
        beat(n1234, ONES, 2'b01);
        beat(n1234, ONES, 2'b11);
        @(negedge clk);
        vld_i = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_result", 64'(result),  64'd0);
        chk("midrst_vld_o",  64'(vld_o),   64'd0);
        chk("midrst_ovf_o",  64'(ovf_o),   64'd0);
        chk("midrst_beats",  64'(beats_o), 64'd0);

        // accumulate onto the cleared acc, then a fresh load
        beat(N5, W3, 2'b11);            expect_out(32'd60, 1'b0, 16'd1);
        beat(N5, WM1, 2'b10);           expect_out(32'hFFFF_FFEC, 1'b0, 16'd1);
        bubble();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
